data_mem_responder: RTL and testbench

Data-memory responder that serves the core's load/store requests (lw, sw, lb, sb) over a valid/ready request channel and a single-pulse response channel. It sits on the memory side of the data port: the core initiates, and this block accepts, waits a fixed latency, performs the access, and responds. It holds the word-organised storage array with byte-lane write merge and sign-extended byte reads.

---
 rtl/dm_pkg.sv | 29 ++
 rtl/dm_lane_unit.sv | 22 ++
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned LANES   = 4;
   localparam int unsigned LANE_W  = 2;
   localparam int unsigned LAT_MIN = 1;
   localparam int unsigned LAT_MAX = 15;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic              we;
      logic              is_byte;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dm_req_t;

   function automatic logic [DATA_W-1:0] sext_byte(input logic [BYTE_W-1:0] b);
      return {{(DATA_W - BYTE_W){b[BYTE_W-1]}}, b};
   endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane merge for stores and lane select / sign extension for loads.
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [LANE_W-1:0] lane,
   input  logic [BYTE_W-1:0] wbyte,
   input  logic              is_byte,
   output logic [DATA_W-1:0] merged_c,
   output logic [DATA_W-1:0] load_c
);

   logic [BYTE_W-1:0] sel_byte;

   always_comb begin
      sel_byte = word[lane*BYTE_W +: BYTE_W];
      merged_c = word;
      merged_c[lane*BYTE_W +: BYTE_W] = wbyte;
      load_c   = is_byte ? sext_byte(sel_byte) : word;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for lw/sw/lb/sb with byte-lane merge.
// Optional misaligned word-access trap: define DM_UNALIGNED_TRAP_EN.
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned      DEPTH    = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("data_mem_responder: LATENCY outside legal range");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dm_req_t           req_q, req_d, op;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              commit;
   logic              misaligned;
   logic              wr_en;
   logic [ADDR_W-1:0] word_idx;
   logic [LANE_W-1:0] lane;
   logic [DATA_W-1:0] rd_word, merged, load_val, wr_word;
   logic              unused_addr_hi;

   logic [DATA_W-1:0] mem [DEPTH];

   // Live inputs in IDLE (a LATENCY=1 access commits on the accept edge), captured copy afterwards
   always_comb begin
      op = req_q;
      if (state_q == IDLE) begin
         op.we      = req_we;
         op.is_byte = req_byte;
         op.addr    = req_addr;
         op.wdata   = req_wdata;
      end
   end

   assign word_idx       = op.addr[ADDR_W+1:2];
   assign lane           = op.addr[1:0];
   assign rd_word        = mem[word_idx];
   assign unused_addr_hi = ^op.addr[DATA_W-1:ADDR_W+2];

`ifdef DM_UNALIGNED_TRAP_EN
   assign misaligned = !op.is_byte && (lane != '0);
`else
   assign misaligned = 1'b0;
`endif

   dm_lane_unit u_lane (
      .word     (rd_word),
      .lane     (lane),
      .wbyte    (op.wdata[BYTE_W-1:0]),
      .is_byte  (op.is_byte),
      .merged_c (merged),
      .load_c   (load_val)
   );

   assign wr_word = op.is_byte ? merged : op.wdata;
   assign wr_en   = commit && op.we && !misaligned && !reset;

   // Next-state, capture and response logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d = op;
               cnt_d = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit) begin
         rdata_d = (op.we || misaligned) ? '0 : load_val;
         err_d   = misaligned;
      end
      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[word_idx] <= wr_word;
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder against a byte-addressed memory model.
module tb_data_mem_responder;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned LAT    = 2;
   localparam logic [31:0] AMASK  = 32'((64'd1 << (ADDR_W + 2)) - 1);
`ifdef DM_UNALIGNED_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_byte;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] mbytes [int];

   data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Expected response from the byte-level memory image; mask clears never-written bytes
   function automatic void model_expect(input logic we, input logic byt, input logic [31:0] addr,
                                        output logic [31:0] rdata, output logic [31:0] mask,
                                        output logic err);
      int  a;
      int  base;
      bit  mis;
      logic [7:0] b;
      a     = int'(addr & AMASK);
      base  = a - (a % 4);
      mis   = (a % 4) != 0;
      rdata = '0;
      mask  = '1;
      err   = 1'b0;
      if (we) begin
         err = !byt && TRAP && mis;
      end else if (byt) begin
         if (mbytes.exists(a)) begin
            b     = mbytes[a];
            rdata = {{24{b[7]}}, b};
         end else begin
            mask = '0;
         end
      end else if (TRAP && mis) begin
         err = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (mbytes.exists(base + i)) rdata[8*i +: 8] = mbytes[base + i];
            else mask[8*i +: 8] = 8'h00;
         end
      end
   endfunction

   function automatic void model_store(input logic byt, input logic [31:0] addr, input logic [31:0] wdata);
      int a;
      int base;
      a    = int'(addr & AMASK);
      base = a - (a % 4);
      if (byt) mbytes[a] = wdata[7:0];
      else if (!(TRAP && (a % 4) != 0))
         for (int i = 0; i < 4; i++) mbytes[base + i] = wdata[8*i +: 8];
   endfunction

   task automatic do_txn(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
      logic [31:0] exp_d, exp_m, got_d;
      logic        exp_e, got_e;
      int          first_v, vcount, low, k;
      bit          done;
      model_expect(we, byt, addr, exp_d, exp_m, exp_e);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL %s accept timeout ready=%0b", name, req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (we) model_store(byt, addr, wdata);
      first_v = -1; vcount = 0; low = 0; got_d = '0; got_e = 1'b0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (rsp_valid) begin
            if (first_v < 0) first_v = i;
            vcount++;
            got_d = rsp_rdata;
            got_e = rsp_err;
         end
         if (req_ready) done = 1;
         else begin
            low++;
            @(posedge clk); #1;
         end
      end
      checks++;
      if (first_v !== int'(LAT)) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, first_v, LAT); end
      checks++;
      if (vcount !== 1) begin errors++; $display("FAIL %s pulse_count got %0d exp 1", name, vcount); end
      checks++;
      if (low !== int'(LAT) + 1) begin errors++; $display("FAIL %s ready_low got %0d exp %0d", name, low, LAT + 1); end
      checks++;
      if ((got_d & exp_m) !== (exp_d & exp_m)) begin
         errors++; $display("FAIL %s rdata got %h exp %h mask %h", name, got_d, exp_d, exp_m);
      end
      checks++;
      if (got_e !== exp_e) begin errors++; $display("FAIL %s err got %0b exp %0b", name, got_e, exp_e); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", rsp_err); end
      reset = 1'b0;
   endtask

   task automatic test_word_roundtrip();
      do_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "sw_10");
      do_txn(1'b0, 1'b0, 32'h10, 32'h0, "lw_10");
   endtask

   task automatic test_byte_lanes();
      do_txn(1'b1, 1'b1, 32'h11, 32'h00000080, "sb_11");
      do_txn(1'b0, 1'b0, 32'h10, 32'h0, "lw_10_merged");
      do_txn(1'b0, 1'b1, 32'h11, 32'h0, "lb_11");
      do_txn(1'b0, 1'b1, 32'h10, 32'h0, "lb_10");
      do_txn(1'b0, 1'b1, 32'h13, 32'h0, "lb_13");
      do_txn(1'b1, 1'b1, 32'h12, 32'h0000007F, "sb_12");
      do_txn(1'b0, 1'b1, 32'h12, 32'h0, "lb_12");
   endtask

   task automatic test_misaligned();
      do_txn(1'b0, 1'b0, 32'h12, 32'h0, "lw_12_misaligned");
      do_txn(1'b1, 1'b0, 32'h16, 32'hCAFEF00D, "sw_16_misaligned");
      do_txn(1'b0, 1'b0, 32'h14, 32'h0, "lw_14_after_misaligned_sw");
   endtask

   task automatic test_reset_abort();
      int vcount;
      do_txn(1'b1, 1'b0, 32'h20, 32'h0, "sw_20_zero");
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'h12345678;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_before got %0b exp 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      vcount = 0;
      if (rsp_valid) vcount++;
      @(posedge clk); #1;
      if (rsp_valid) vcount++;
      reset = 1'b1;
      @(posedge clk); #1;
      if (rsp_valid) vcount++;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) vcount++;
      end
      checks++;
      if (vcount !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d pulses exp 0", vcount); end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %0b exp 1", req_ready); end
      do_txn(1'b0, 1'b0, 32'h20, 32'h0, "lw_20_after_abort");
   endtask

   task automatic test_back_to_back_wrap();
      logic [31:0] exp_d, exp_m, got_d;
      logic        exp_e, rdy_idle, rdy_acc;
      int          v1, v2;
      model_store(1'b0, 32'h4000, 32'h1);
      model_expect(1'b0, 1'b0, 32'h0, exp_d, exp_m, exp_e);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h4000; req_wdata = 32'h1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_start got %0b exp 1", req_ready); end
      @(posedge clk); #1;
      req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
      v1 = -1; v2 = -1; got_d = '0; rdy_idle = 1'b0; rdy_acc = 1'b1;
      for (int i = 0; i < 30 && v2 < 0; i++) begin
         if (i == int'(LAT) + 1) rdy_idle = req_ready;
         if (i == int'(LAT) + 2) rdy_acc = req_ready;
         if (rsp_valid) begin
            if (v1 < 0) v1 = i;
            else begin v2 = i; got_d = rsp_rdata; end
         end
         if (v2 < 0) begin @(posedge clk); #1; end
      end
      req_valid = 1'b0;
      checks++;
      if (v1 !== int'(LAT)) begin errors++; $display("FAIL b2b_first_rsp got %0d exp %0d", v1, LAT); end
      checks++;
      if (rdy_idle !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got %0b exp 1", rdy_idle); end
      checks++;
      if (rdy_acc !== 1'b0) begin errors++; $display("FAIL b2b_second_accept ready got %0b exp 0", rdy_acc); end
      checks++;
      if (v2 !== 2 * int'(LAT) + 2) begin errors++; $display("FAIL b2b_second_rsp got %0d exp %0d", v2, 2 * LAT + 2); end
      checks++;
      if ((got_d & exp_m) !== (exp_d & exp_m)) begin
         errors++; $display("FAIL b2b_wrap_rdata got %h exp %h", got_d, exp_d);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic        we, byt;
      for (int w = 0; w < 16; w++)
         do_txn(1'b1, 1'b0, 32'h100 + 32'(4 * w), $urandom, "rand_fill");
      for (int n = 0; n < 60; n++) begin
         we   = 1'($urandom_range(0, 1));
         byt  = 1'($urandom_range(0, 1));
         addr = ($urandom & 32'hFFFF_C000) | 32'h100 | 32'($urandom_range(0, 63));
         do_txn(we, byt, addr, $urandom, "rand_op");
      end
   endtask

   initial begin
      test_reset();
      test_word_roundtrip();
      test_byte_lanes();
      test_misaligned();
      test_reset_abort();
      test_back_to_back_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
